mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_select.sv | 44 ++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and constants for the memory arbiter: the
//                controller state encoding and the arbitration mode codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

   // Controller state: waiting for a requester, or owning the memory port
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Values accepted by the RR_MODE parameter
   localparam int c_RR_MODE_FIXED       = 0;
   localparam int c_RR_MODE_ROUND_ROBIN = 1;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select
//  Description : Combinational winner search over a pending vector. In
//                round-robin mode the search starts one past the previous
//                winner and wraps; in fixed mode it always starts at port 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_select
   import arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int IDX_WIDTH = 1
) (
   input  logic [NUM_PORTS-1:0] pending,
   input  logic [IDX_WIDTH-1:0] last_grant,
   input  logic                 rr_mode,
   output logic [IDX_WIDTH-1:0] winner,
   output logic                 valid
);

   int                   w_start;
   logic [IDX_WIDTH-1:0] w_idx;

   // Walk the ports in priority order from the start point; first pending one wins
   always_comb begin
      winner  = '0;
      valid   = 1'b0;
      w_start = 0;
      w_idx   = '0;
      if (rr_mode) begin
         w_start = (int'(last_grant) + 1) % NUM_PORTS;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_idx = IDX_WIDTH'((w_start + i) % NUM_PORTS);
         if (!valid && pending[w_idx]) begin
            valid  = 1'b1;
            winner = w_idx;
         end
      end
   end

endmodule : rr_select
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one memory port between NUM_PORTS requesters. A
//                winner is picked in IDLE, its request is latched, and the
//                memory side is driven only from the latched copy until
//                mem_resp, which is forwarded as a one-cycle req_resp pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 256,
   parameter int RR_MODE    = 1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_PORTS-1:0]                 req_read,
   input  logic [NUM_PORTS-1:0]                 req_write,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_address,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata,
   output logic [DATA_WIDTH-1:0]                req_rdata,
   output logic [NUM_PORTS-1:0]                 req_resp,
   output logic                                 mem_read,
   output logic                                 mem_write,
   output logic [ADDR_WIDTH-1:0]                mem_address,
   output logic [DATA_WIDTH-1:0]                mem_wdata,
   input  logic [DATA_WIDTH-1:0]                mem_rdata,
   input  logic                                 mem_resp
);

   localparam int   c_IDX_WIDTH = $clog2(NUM_PORTS);
   localparam logic c_RR_EN     = (RR_MODE == c_RR_MODE_ROUND_ROBIN);

   arb_state_t              r_state;
   arb_state_t              w_state_next;
   logic [c_IDX_WIDTH-1:0]  r_last_grant;
   logic [c_IDX_WIDTH-1:0]  r_winner;
   logic [c_IDX_WIDTH-1:0]  w_winner;
   logic                    w_valid;
   logic                    w_grant;
   logic                    w_busy;
   logic [NUM_PORTS-1:0]    w_pending;
   logic                    r_is_write;
   logic [ADDR_WIDTH-1:0]   r_address;
   logic [DATA_WIDTH-1:0]   r_wdata;

   assign w_pending = req_read | req_write;

   rr_select #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_WIDTH (c_IDX_WIDTH)
   ) u_rr_select (
      .pending    (w_pending),
      .last_grant (r_last_grant),
      .rr_mode    (c_RR_EN),
      .winner     (w_winner),
      .valid      (w_valid)
   );

   // Next-state decode: grant from IDLE when anyone is pending, release on mem_resp
   always_comb begin
      w_state_next = r_state;
      w_grant      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_grant      = 1'b1;
               w_state_next = BUSY;
            end
         end
         BUSY: begin
            if (mem_resp) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State register; reset mid-transaction simply abandons the transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Capture the winner's request on the grant edge; rotation pointer starts at the last port
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= c_IDX_WIDTH'(NUM_PORTS - 1);
         r_winner     <= '0;
         r_is_write   <= 1'b0;
         r_address    <= '0;
         r_wdata      <= '0;
      end else if (w_grant) begin
         r_winner   <= w_winner;
         r_is_write <= req_write[w_winner];
         r_address  <= req_address[w_winner];
         r_wdata    <= req_wdata[w_winner];
         if (c_RR_EN) begin
            r_last_grant <= w_winner;
         end
      end
   end

   // Memory side reflects only latched values; a read+write request goes out as a write
   assign w_busy      = (r_state == BUSY);
   assign mem_read    = w_busy & ~r_is_write;
   assign mem_write   = w_busy &  r_is_write;
   assign mem_address = r_address;
   assign mem_wdata   = r_wdata;
   assign req_rdata   = mem_rdata;

   // Completion pulse to the owning port, same cycle as mem_resp, only while BUSY
   always_comb begin
      req_resp = '0;
      if (w_busy && mem_resp) begin
         req_resp[r_winner] = 1'b1;
      end
   end

endmodule : mem_arbiter
`default_nettype wire
